// File: rtl/lieat_axi_rd_arb_pkg.sv
// Shared types and constants for the instruction/load AXI read-channel arbiter.
package lieat_axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } owner_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [3:0] ICACHE_ID_DEF = 4'h0;
    localparam logic [3:0] DCACHE_ID_DEF = 4'h1;
    localparam logic [2:0] IC_ARSIZE_DEF = 3'b010;

    // Width of the starvation counter; STARVE_MAX is limited to 1..15.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/lieat_rr_starve_cnt.sv
// Grant decision for the read arbiter: dcache wins unless icache has been
// passed over STARVE_MAX times in a row, tracked by a saturating counter.
module lieat_rr_starve_cnt
    import lieat_axi_rd_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic idle,
    input  logic ic_req,
    input  logic dc_req,
    output logic grant_ic,
    output logic grant_dc
);

    localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_reg;
    logic [STARVE_W-1:0] cnt_next;

    always_comb begin
        grant_dc = idle && dc_req && (cnt_reg < MAX_CNT);
        grant_ic = idle && ic_req && !grant_dc;
        cnt_next = cnt_reg;
        if (grant_ic) begin
            cnt_next = '0;
        end else if (grant_dc && ic_req && (cnt_reg != '1)) begin
            // Only a dcache win that leaves icache waiting counts toward starvation.
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/lieat_axi_rd_arb.sv
// Shares one AXI read port between instruction fetch and the load path with a
// single outstanding transaction, per-requester ARID and R-beat routing.
module lieat_axi_rd_arb
    import lieat_axi_rd_arb_pkg::*;
#(
    parameter int         STARVE_MAX = 4,
    parameter logic [3:0] ICACHE_ID  = ICACHE_ID_DEF,
    parameter logic [3:0] DCACHE_ID  = DCACHE_ID_DEF,
    parameter logic [2:0] IC_ARSIZE  = IC_ARSIZE_DEF
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        icache_axi_arvalid,
    output logic        icache_axi_arready,
    input  logic [31:0] icache_axi_araddr,
    output logic        icache_axi_rvalid,
    input  logic        icache_axi_rready,
    output logic [31:0] icache_axi_rdata,

    input  logic        dcache_axi_arvalid,
    output logic        dcache_axi_arready,
    input  logic [31:0] dcache_axi_araddr,
    input  logic [2:0]  dcache_axi_arsize,
    output logic        dcache_axi_rvalid,
    input  logic        dcache_axi_rready,
    output logic [31:0] dcache_axi_rdata,

    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic [3:0]  m_rid,

    output logic        rd_err
);

    arb_state_t  state_reg;
    arb_state_t  state_next;
    logic [31:0] addr_reg;
    logic [2:0]  size_reg;
    logic [3:0]  id_reg;
    owner_t      owner_reg;
    logic        rd_err_reg;

    logic grant_ic;
    logic grant_dc;
    logic owner_rready;
    logic beat;

    lieat_rr_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rstn     (rstn),
        .idle     (state_reg == ST_IDLE),
        .ic_req   (icache_axi_arvalid),
        .dc_req   (dcache_axi_arvalid),
        .grant_ic (grant_ic),
        .grant_dc (grant_dc)
    );

    assign owner_rready = (owner_reg == OWN_DCACHE) ? dcache_axi_rready : icache_axi_rready;
    assign beat         = (state_reg == ST_DATA) && m_rvalid && owner_rready;

    always_comb begin
        state_next         = state_reg;
        icache_axi_arready = 1'b0;
        dcache_axi_arready = 1'b0;
        icache_axi_rvalid  = 1'b0;
        dcache_axi_rvalid  = 1'b0;
        m_arvalid          = 1'b0;
        m_rready           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                icache_axi_arready = grant_ic;
                dcache_axi_arready = grant_dc;
                if (grant_ic || grant_dc) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                m_rready = owner_rready;
                if (owner_reg == OWN_DCACHE) begin
                    dcache_axi_rvalid = m_rvalid;
                end else begin
                    icache_axi_rvalid = m_rvalid;
                end
                if (beat && m_rlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            size_reg   <= '0;
            id_reg     <= '0;
            owner_reg  <= OWN_ICACHE;
            rd_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_dc) begin
                addr_reg  <= dcache_axi_araddr;
                size_reg  <= dcache_axi_arsize;
                id_reg    <= DCACHE_ID;
                owner_reg <= OWN_DCACHE;
            end else if (grant_ic) begin
                addr_reg  <= icache_axi_araddr;
                size_reg  <= IC_ARSIZE;
                id_reg    <= ICACHE_ID;
                owner_reg <= OWN_ICACHE;
            end
            // Bad responses are flagged but the beat is still handed to the owner.
            rd_err_reg <= beat && ((m_rresp != AXI_RESP_OKAY) || (m_rid != id_reg));
        end
    end

    assign m_araddr         = addr_reg;
    assign m_arid           = id_reg;
    assign m_arsize         = size_reg;
    assign m_arlen          = 8'd0;
    assign m_arburst        = AXI_BURST_INCR;
    assign icache_axi_rdata = m_rdata;
    assign dcache_axi_rdata = m_rdata;
    assign rd_err           = rd_err_reg;

endmodule

// File: doc/lieat_axi_rd_arb.md
Name: lieat_axi_rd_arb

Overview:
Read-channel arbiter that shares the single AXI read port between the IFU instruction fetch (icache_axi_*) and the EXU load path (dcache_axi_*). It sits between the two requesters and the AR/R side of the AXI master. It keeps exactly one read transaction outstanding, tags each transaction with a per-requester ARID, and routes R beats back to the owning requester. Arbitration is dcache-priority, with a starvation guard that forces an icache grant.

Parameters:
STARVE_MAX, 4, consecutive dcache wins while icache waits before icache is forced to win (1..15)
ICACHE_ID, 4'h0, ARID used for icache reads
DCACHE_ID, 4'h1, ARID used for dcache reads
IC_ARSIZE, 3'b010, fixed ARSIZE for instruction fetch (32-bit)

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
icache_axi_arvalid  in  1  icache read request
icache_axi_arready  out  1  icache request accepted
icache_axi_araddr  in  32  icache read address
icache_axi_rvalid  out  1  icache read data valid
icache_axi_rready  in  1  icache accepts data
icache_axi_rdata  out  32  icache read data
dcache_axi_arvalid  in  1  dcache read request
dcache_axi_arready  out  1  dcache request accepted
dcache_axi_araddr  in  32  dcache read address
dcache_axi_arsize  in  3  dcache access size
dcache_axi_rvalid  out  1  dcache read data valid
dcache_axi_rready  in  1  dcache accepts data
dcache_axi_rdata  out  32  dcache read data
m_arvalid/m_arready  out/in  1/1  master AR handshake
m_araddr  out  32  latched address
m_arid  out  4  owner ID
m_arlen/m_arsize/m_arburst  out  8/3/2  always 0 / latched size / 2'b01 (INCR)
m_rvalid/m_rready  in/out  1/1  master R handshake
m_rdata  in  32  read data
m_rresp  in  2  response
m_rlast  in  1  last beat
m_rid  in  4  response ID
rd_err  out  1  one-cycle pulse on SLVERR/DECERR or RID mismatch

Behaviour:
- Clock is clk; reset is rstn, asynchronous and active-low.
- The block has three states: IDLE, ADDR, DATA.
- Reset values: IDLE; m_arvalid=0; all arready/rvalid=0; owner=icache; latched addr/size/id=0; starve_cnt=0; rd_err=0.
- IDLE grant rule: if dcache_axi_arvalid and starve_cnt<STARVE_MAX, grant dcache. Otherwise, if icache_axi_arvalid, grant icache.
- Grant handshake: the granted requester's arready=1 combinationally in the same cycle. The other requester's arready=0. The block latches addr, size (IC_ARSIZE for icache), id and owner, then moves to ADDR.
- starve_cnt: increments (saturating) when dcache wins while icache_axi_arvalid=1. It clears to 0 on an icache grant and is unchanged otherwise.
- ADDR: m_arvalid=1. addr/id/size stay stable until m_arready, then the block moves to DATA. m_arvalid rises the cycle after the requester handshake (1-cycle AR latency).
- DATA: m_rready = owner's rready. Owner's rvalid = m_rvalid. rdata is passed combinationally to both requesters. The non-owner's rvalid=0.
- A beat transfers when m_rvalid & m_rready. A transfer with m_rlast=1 returns the block to IDLE, so a new grant is possible in that same IDLE cycle (the next clock).
- rd_err pulses for one cycle on a transfer with m_rresp!=0 or m_rid!=latched id. The data is still delivered to the owner.
- No new AR is issued while in ADDR or DATA. Both arready=0 outside IDLE.
- Requester requirement: a requester must not drop arvalid before arready.
- Asynchronous reset mid-transaction abandons it. All outputs return to reset values immediately. Any in-flight R beat arriving after reset is the master's responsibility.

Decomposition:
- Shared package: state encoding (IDLE/ADDR/DATA), AXI burst/resp constants (INCR=2'b01, OKAY=2'b00), requester ID constants.
- One sub-module, lieat_rr_starve_cnt: the saturating starvation counter plus the grant decision. Everything else is inline.

Test Plan:
1. Icache alone, araddr=0x8000_0000 → m_arvalid next cycle, arid=0, arsize=010. Respond rdata=0x00000013, rlast=1 → icache_axi_rvalid=1 with that data; dcache_axi_rvalid=0.
2. Both request every cycle → grants go dcache×4, then icache×1, repeating; starve_cnt returns to 0 after each icache grant.
3. Master delays m_arready 5 cycles → m_araddr/m_arid stable throughout; no second arready is asserted.
4. Owner dcache holds rready=0 for 3 cycles while m_rvalid=1 → m_rready=0 for those cycles; the beat transfers when rready rises; state returns to IDLE.
5. R beat with rresp=2'b10, or rid=4'h7 while the latched id is 1 → rd_err pulses for exactly 1 cycle; data is still delivered.
6. rstn low while in DATA → m_rready, m_arvalid and all rvalid are 0 immediately; after release the first request is granted normally.
